// File: rtl/pulse_monitor_if.sv
// ============================================================================
// Module : pulse_monitor_if
// Brief  : Bundle of pulse input, clear and measurement outputs of the
//          pulse monitor. Min/max fields exist only with PMON_MINMAX_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface pulse_monitor_if #(
  parameter int CNT_W = 16
) ();
  logic             pulse;
  logic             clr;
  logic [CNT_W-1:0] period;
  logic             period_vld;
  logic [CNT_W-1:0] pulse_cnt;
  logic             missing;
  logic [1:0]       state;
`ifdef PMON_MINMAX_EN
  logic [CNT_W-1:0] period_min;
  logic [CNT_W-1:0] period_max;
`endif

  modport master (
    output pulse,
    output clr,
    input  period,
    input  period_vld,
    input  pulse_cnt,
    input  missing,
    input  state
`ifdef PMON_MINMAX_EN
    ,
    input  period_min,
    input  period_max
`endif
  );

  modport slave (
    input  pulse,
    input  clr,
    output period,
    output period_vld,
    output pulse_cnt,
    output missing,
    output state
`ifdef PMON_MINMAX_EN
    ,
    output period_min,
    output period_max
`endif
  );
endinterface

`default_nettype wire

// File: rtl/pulse_monitor.sv
// ============================================================================
// Module : pulse_monitor
// Brief  : Measures rising-edge interval of a pulse train, counts edges and
//          raises a sticky alarm on timeout. Optional min/max tracking is
//          enabled by defining PMON_MINMAX_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module pulse_monitor #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 200
) (
  input  wire logic     clk,
  input  wire logic     rst,
  pulse_monitor_if.slave mon
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ARMED = 2'b01,
    S_ALARM = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] C_ZERO    = '0;
  localparam logic [CNT_W-1:0] C_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_ALL1    = '1;
  localparam logic [CNT_W-1:0] C_TIMEOUT = CNT_W'(TIMEOUT);

  state_t           state_q,      state_d;
  logic             pulse_d_q;
  logic [CNT_W-1:0] ivl_q,        ivl_d;
  logic [CNT_W-1:0] period_q,     period_d;
  logic             period_vld_q, period_vld_d;
  logic [CNT_W-1:0] pulse_cnt_q,  pulse_cnt_d;
  logic             missing_q,    missing_d;
`ifdef PMON_MINMAX_EN
  logic [CNT_W-1:0] period_min_q, period_min_d;
  logic [CNT_W-1:0] period_max_q, period_max_d;
`endif

  logic             rise;
  logic [CNT_W-1:0] ivl_inc;

  assign rise    = mon.pulse & ~pulse_d_q;
  assign ivl_inc = ivl_q + C_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pulse_d_q    <= 1'b0;
      ivl_q        <= C_ZERO;
      period_q     <= C_ZERO;
      period_vld_q <= 1'b0;
      pulse_cnt_q  <= C_ZERO;
      missing_q    <= 1'b0;
`ifdef PMON_MINMAX_EN
      period_min_q <= C_ALL1;
      period_max_q <= C_ZERO;
`endif
    end else begin
      state_q      <= state_d;
      pulse_d_q    <= mon.pulse;
      ivl_q        <= ivl_d;
      period_q     <= period_d;
      period_vld_q <= period_vld_d;
      pulse_cnt_q  <= pulse_cnt_d;
      missing_q    <= missing_d;
`ifdef PMON_MINMAX_EN
      period_min_q <= period_min_d;
      period_max_q <= period_max_d;
`endif
    end
  end

  always_comb begin
    state_d      = state_q;
    ivl_d        = ivl_q;
    period_d     = period_q;
    period_vld_d = 1'b0;
    pulse_cnt_d  = pulse_cnt_q;
    missing_d    = missing_q;
`ifdef PMON_MINMAX_EN
    period_min_d = period_min_q;
    period_max_d = period_max_q;
`endif

    // Clear overrides everything, including an edge arriving on the same cycle.
    if (mon.clr) begin
      state_d     = S_IDLE;
      ivl_d       = C_ZERO;
      period_d    = C_ZERO;
      pulse_cnt_d = C_ZERO;
      missing_d   = 1'b0;
`ifdef PMON_MINMAX_EN
      period_min_d = C_ALL1;
      period_max_d = C_ZERO;
`endif
    end else begin
      if (rise && (pulse_cnt_q != C_ALL1)) begin
        pulse_cnt_d = pulse_cnt_q + C_ONE;
      end

      case (state_q)
        S_IDLE: begin
          if (rise) begin
            state_d = S_ARMED;
            ivl_d   = C_ZERO;
          end
        end

        S_ARMED: begin
          // A rise on the timeout cycle still yields an accepted interval.
          if (rise) begin
            period_d     = ivl_inc;
            period_vld_d = 1'b1;
            ivl_d        = C_ZERO;
`ifdef PMON_MINMAX_EN
            if (ivl_inc < period_min_q) begin
              period_min_d = ivl_inc;
            end
            if (ivl_inc > period_max_q) begin
              period_max_d = ivl_inc;
            end
`endif
          end else if (ivl_inc == C_TIMEOUT) begin
            state_d   = S_ALARM;
            missing_d = 1'b1;
          end else begin
            ivl_d = ivl_inc;
          end
        end

        S_ALARM: begin
          if (rise) begin
            state_d = S_ARMED;
            ivl_d   = C_ZERO;
          end
        end

        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  assign mon.period     = period_q;
  assign mon.period_vld = period_vld_q;
  assign mon.pulse_cnt  = pulse_cnt_q;
  assign mon.missing    = missing_q;
  assign mon.state      = state_q;
`ifdef PMON_MINMAX_EN
  assign mon.period_min = period_min_q;
  assign mon.period_max = period_max_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pulse_monitor.sv
// ============================================================================
// Module : tb_pulse_monitor
// Brief  : Scenario-driven bench for pulse_monitor with a scoreboard of
//          expected periods consumed on each period_vld strobe.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_pulse_monitor;

  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 200;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int unsigned exp_q[$];

  pulse_monitor_if #(.CNT_W(CNT_W)) mon ();

  pulse_monitor #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (mon)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard consumer: every strobe must match the oldest expected period.
  always @(negedge clk) begin
    if (!rst && mon.period_vld === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_unexpected: period_vld=1 period=%0d, required no strobe", mon.period);
      end else begin
        int unsigned e;
        e = exp_q.pop_front();
        if (mon.period !== CNT_W'(e)) begin
          errors++;
          $display("FAIL period_value: got %0d, required %0d", mon.period, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    mon.clr = 1'b1;
    tick();
    mon.clr = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    mon.clr   = 1'b0;
    mon.pulse = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mon.pulse = ~mon.pulse;
      tick();
      checks++;
      if (mon.period !== '0 || mon.period_vld !== 1'b0 || mon.pulse_cnt !== '0 ||
          mon.missing !== 1'b0 || mon.state !== 2'b00) begin
        errors++;
        $display("FAIL reset_values: period=%0d vld=%b cnt=%0d missing=%b state=%b, required 0/0/0/0/00",
                 mon.period, mon.period_vld, mon.pulse_cnt, mon.missing, mon.state);
      end
    end
    mon.pulse = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_repeated();
    do_clr();
    mon.pulse = 1'b1;
    tick();
    mon.pulse = 1'b0;
    checks++;
    if (mon.state !== 2'b01 || mon.period_vld !== 1'b0 || mon.pulse_cnt !== 16'd1) begin
      errors++;
      $display("FAIL repeated_first: state=%b vld=%b cnt=%0d, required 01/0/1",
               mon.state, mon.period_vld, mon.pulse_cnt);
    end
    repeat (9) tick();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(10);
      mon.pulse = 1'b1;
      tick();
      mon.pulse = 1'b0;
      checks++;
      if (mon.period_vld !== 1'b1 || mon.pulse_cnt !== CNT_W'(i + 2) || mon.state !== 2'b01) begin
        errors++;
        $display("FAIL repeated_edge: vld=%b cnt=%0d state=%b, required 1/%0d/01",
                 mon.period_vld, mon.pulse_cnt, mon.state, i + 2);
      end
      tick();
      checks++;
      if (mon.period_vld !== 1'b0) begin
        errors++;
        $display("FAIL strobe_width: vld=%b one cycle after edge, required 0", mon.period_vld);
      end
      repeat (8) tick();
    end
`ifdef PMON_MINMAX_EN
    checks++;
    if (mon.period_min !== 16'd10 || mon.period_max !== 16'd10) begin
      errors++;
      $display("FAIL minmax_repeated: min=%0d max=%0d, required 10/10", mon.period_min, mon.period_max);
    end
`endif
  endtask

  task automatic test_single_shot();
    do_clr();
    mon.pulse = 1'b1;
    tick();
    mon.pulse = 1'b0;
    repeat (TIMEOUT - 1) tick();
    checks++;
    if (mon.missing !== 1'b0 || mon.state !== 2'b01) begin
      errors++;
      $display("FAIL timeout_early: missing=%b state=%b, required 0/01", mon.missing, mon.state);
    end
    tick();
    checks++;
    if (mon.missing !== 1'b1 || mon.state !== 2'b10) begin
      errors++;
      $display("FAIL timeout_alarm: missing=%b state=%b, required 1/10", mon.missing, mon.state);
    end
    repeat (5) tick();
    mon.pulse = 1'b1;
    tick();
    mon.pulse = 1'b0;
    checks++;
    if (mon.state !== 2'b01 || mon.missing !== 1'b1 || mon.period_vld !== 1'b0 || mon.pulse_cnt !== 16'd2) begin
      errors++;
      $display("FAIL alarm_rearm: state=%b missing=%b vld=%b cnt=%0d, required 01/1/0/2",
               mon.state, mon.missing, mon.period_vld, mon.pulse_cnt);
    end
    repeat (9) tick();
    exp_q.push_back(10);
    mon.pulse = 1'b1;
    tick();
    mon.pulse = 1'b0;
    checks++;
    if (mon.period !== 16'd10 || mon.missing !== 1'b1) begin
      errors++;
      $display("FAIL after_alarm_period: period=%0d missing=%b, required 10/1", mon.period, mon.missing);
    end
    tick();
  endtask

  task automatic test_hold();
    do_clr();
    mon.pulse = 1'b1;
    repeat (5) tick();
    mon.pulse = 1'b0;
    repeat (3) tick();
    checks++;
    if (mon.pulse_cnt !== 16'd1 || mon.state !== 2'b01) begin
      errors++;
      $display("FAIL hold_count: cnt=%0d state=%b, required 1/01", mon.pulse_cnt, mon.state);
    end
  endtask

  task automatic test_boundary();
    do_clr();
    mon.pulse = 1'b1;
    tick();
    mon.pulse = 1'b0;
    repeat (TIMEOUT - 1) tick();
    exp_q.push_back(TIMEOUT);
    mon.pulse = 1'b1;
    tick();
    mon.pulse = 1'b0;
    checks++;
    if (mon.period !== CNT_W'(TIMEOUT) || mon.period_vld !== 1'b1 || mon.missing !== 1'b0 || mon.state !== 2'b01) begin
      errors++;
      $display("FAIL boundary_accept: period=%0d vld=%b missing=%b state=%b, required 200/1/0/01",
               mon.period, mon.period_vld, mon.missing, mon.state);
    end
`ifdef PMON_MINMAX_EN
    checks++;
    if (mon.period_min !== 16'd200 || mon.period_max !== 16'd200) begin
      errors++;
      $display("FAIL minmax_boundary: min=%0d max=%0d, required 200/200", mon.period_min, mon.period_max);
    end
`endif
    repeat (TIMEOUT - 1) tick();
    checks++;
    if (mon.missing !== 1'b0) begin
      errors++;
      $display("FAIL boundary_pre: missing=%b, required 0", mon.missing);
    end
    tick();
    checks++;
    if (mon.missing !== 1'b1 || mon.state !== 2'b10) begin
      errors++;
      $display("FAIL boundary_201: missing=%b state=%b, required 1/10", mon.missing, mon.state);
    end
    mon.pulse = 1'b1;
    tick();
    mon.pulse = 1'b0;
    tick();
  endtask

  task automatic test_clr_rise();
    do_clr();
    mon.pulse = 1'b1;
    tick();
    mon.pulse = 1'b0;
    repeat (TIMEOUT + 3) tick();
    mon.pulse = 1'b1;
    tick();
    mon.pulse = 1'b0;
    repeat (4) tick();
    checks++;
    if (mon.state !== 2'b01 || mon.missing !== 1'b1) begin
      errors++;
      $display("FAIL clr_setup: state=%b missing=%b, required 01/1", mon.state, mon.missing);
    end
    mon.pulse = 1'b1;
    mon.clr   = 1'b1;
    tick();
    mon.clr   = 1'b0;
    checks++;
    if (mon.state !== 2'b00 || mon.pulse_cnt !== '0 || mon.missing !== 1'b0 ||
        mon.period_vld !== 1'b0 || mon.period !== '0) begin
      errors++;
      $display("FAIL clr_rise: state=%b cnt=%0d missing=%b vld=%b period=%0d, required 00/0/0/0/0",
               mon.state, mon.pulse_cnt, mon.missing, mon.period_vld, mon.period);
    end
    tick();
    checks++;
    if (mon.state !== 2'b00 || mon.pulse_cnt !== '0) begin
      errors++;
      $display("FAIL clr_no_late_edge: state=%b cnt=%0d, required 00/0", mon.state, mon.pulse_cnt);
    end
    mon.pulse = 1'b0;
    tick();
  endtask

  task automatic test_async_rst();
    do_clr();
    mon.pulse = 1'b1;
    tick();
    mon.pulse = 1'b0;
    repeat (9) tick();
    exp_q.push_back(10);
    mon.pulse = 1'b1;
    tick();
    mon.pulse = 1'b0;
    repeat (3) tick();
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (mon.period !== '0 || mon.period_vld !== 1'b0 || mon.pulse_cnt !== '0 ||
        mon.missing !== 1'b0 || mon.state !== 2'b00) begin
      errors++;
      $display("FAIL async_rst: period=%0d vld=%b cnt=%0d missing=%b state=%b, required 0/0/0/0/00",
               mon.period, mon.period_vld, mon.pulse_cnt, mon.missing, mon.state);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (mon.state !== 2'b00 || mon.pulse_cnt !== '0) begin
      errors++;
      $display("FAIL post_rst: state=%b cnt=%0d, required 00/0", mon.state, mon.pulse_cnt);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    mon.pulse = 1'b0;
    mon.clr   = 1'b0;
    test_reset();
    test_repeated();
    test_single_shot();
    test_hold();
    test_boundary();
    test_clr_rise();
    test_async_rst();
    repeat (2) tick();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL strobe_missing: %0d expected periods never strobed, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pulse_monitor.md
# pulse_monitor

Downstream consumer of the periodic/single-shot pulse generator: samples its `pulse` output, measures the interval between successive rising edges in clock cycles, counts edges and raises a sticky alarm when an expected pulse fails to arrive within a timeout. Provides the measurement and health status that the rest of the design uses to check the pulse generator in both single and repeated modes.

## Interface
- `CNT_W`, 16: width of interval, period and edge-count registers.
- `TIMEOUT`, 200: maximum accepted interval in cycles; must satisfy 1 < TIMEOUT < 2^CNT_W.

- `clk`  in  1  system clock, rising-edge active.
- `rst`  in  1  reset, asynchronous, active-high.
- `pulse`  in  1  pulse from generator, synchronous to `clk`; level input, rising edge is the event.
- `clr`  in  1  synchronous clear of measurement state.
- `period`  out  CNT_W  last accepted interval in cycles.
- `period_vld`  out  1  one-cycle strobe when `period` updates.
- `pulse_cnt`  out  CNT_W  rising edges seen since reset/clear, saturating.
- `missing`  out  1  sticky timeout alarm.
- `state`  out  2  FSM state: IDLE=00, ARMED=01, ALARM=10.

## Operation
- Edge detect: `pulse` registered into `pulse_d` (reset 0); `rise = pulse & ~pulse_d`. A pulse held high N cycles is one event.
- Internal interval counter `ivl` (CNT_W bits, reset 0).
- IDLE: on `rise` -> ARMED, `ivl`<=0. No period output.
- ARMED: on `rise` -> `period`<=`ivl`+1, `period_vld`<=1, `ivl`<=0, stay ARMED. Else if `ivl`+1 == TIMEOUT -> ALARM, `missing`<=1. Else `ivl`<=`ivl`+1.
- ALARM: `ivl` frozen. On `rise` -> ARMED, `ivl`<=0, no `period_vld` (interval invalid). `missing` stays 1.
- Rise and timeout on the same cycle: rise wins; interval TIMEOUT is accepted.
- `pulse_cnt` increments on every `rise` in any state; saturates at 2^CNT_W-1.
- `clr`=1: next state IDLE; `ivl`, `period`, `pulse_cnt`, `missing`, `period_vld` cleared; `pulse_d` still tracks `pulse`. `clr` and `rise` simultaneous: `clr` wins, edge dropped (not counted).
- Two rises sampled at cycles n and n+k (k >= 2 due to edge detect) give `period`=k.
- Unused state encoding 11 -> IDLE on next clock.

## Timing
- Reset values: `period`=0, `period_vld`=0, `pulse_cnt`=0, `missing`=0, `state`=00; `ivl`=0, `pulse_d`=0.
- `rst` asserted mid-interval: all outputs return to reset values immediately, independent of `clk`.
- Latency: `period_vld`, `period`, `pulse_cnt` update on the clock edge at which `rise` is sampled; visible for the following cycle. `period_vld` is high exactly one cycle per accepted interval.
- `missing` asserts on the edge at which the TIMEOUT-th cycle after the last edge passes without a rise; stays until `clr` or `rst`.
- All outputs registered; no combinational path from `pulse` to any output.

## Configuration
- `PMON_MINMAX_EN` defined: adds outputs `period_min` (CNT_W, reset and `clr` value all-ones) and `period_max` (CNT_W, reset and `clr` value 0), updated on the same edge as each `period_vld` with min/max of accepted periods.
- Undefined: ports and registers absent; remaining behaviour identical.

## Test plan
- Reset: `rst`=1 with `pulse` toggling -> `period`=0, `period_vld`=0, `pulse_cnt`=0, `missing`=0, `state`=00 throughout.
- Repeated mode, one-cycle pulses every 10 cycles, TIMEOUT=200 -> first edge: `state`=01, no strobe; each later edge: `period`=10, `period_vld` one cycle, `pulse_cnt` 2,3,4...
- Single-shot: one pulse then none -> `missing`=1, `state`=10 after 200 cycles; next pulse -> `state`=01, no `period_vld`, `missing` still 1; pulse 10 cycles later -> `period`=10.
- `pulse` held high 5 cycles, then low -> `pulse_cnt` increments by exactly 1.
- Edge exactly 200 cycles after previous -> `period`=200, `period_vld`=1, `missing`=0; at 201 -> `missing`=1.
- `clr` coincident with a rise while ARMED -> `state`=00, `pulse_cnt`=0, `missing`=0, no strobe; `rst` pulsed mid-interval -> immediate reset values.
